aga_colour_table: RTL

- Parametrised successor to the 32-entry, 12-bit colour lookup table.
- Holds up to 256 palette entries of 24-bit RGB, 8 bits per channel. Each channel is stored as a high nibble and a low nibble.
- Written by the CPU register path using bank select and the LOCT flag (AGA BPLCON3 semantics).
- Read by the pixel pipeline with a bitplane XOR mask (BPLCON4 BPLAM), border blanking, a configurable read latency and an output valid flag. Sits between the pixel priority/mux stage and the video DAC output.

---
 rtl/aga_colour_table_if.sv | 29 ++
 rtl/aga_colour_table.sv | 73 +++++++
 2 files changed

// File: rtl/aga_colour_table_if.sv
// CPU palette-write and pixel-lookup signal bundle for aga_colour_table.
// The master drives writes and lookups; the slave (the table) returns RGB and valid.
interface aga_colour_table_if #(
    parameter int IDX_W = 8
) ();
    logic             cpu_wr;
    logic             cpu_loct;
    logic [2:0]       cpu_bank;
    logic [4:0]       cpu_reg;
    logic [11:0]      cpu_rgb;
    logic             clut_rd;
    logic [IDX_W-1:0] clut_idx;
    logic [IDX_W-1:0] clut_xor;
    logic             clut_blank;
    logic [23:0]      clut_rgb;
    logic             clut_vld;

    modport master (
        output cpu_wr, cpu_loct, cpu_bank, cpu_reg, cpu_rgb,
        output clut_rd, clut_idx, clut_xor, clut_blank,
        input  clut_rgb, clut_vld
    );

    modport slave (
        input  cpu_wr, cpu_loct, cpu_bank, cpu_reg, cpu_rgb,
        input  clut_rd, clut_idx, clut_xor, clut_blank,
        output clut_rgb, clut_vld
    );
endinterface

// File: rtl/aga_colour_table.sv
// AGA palette: 2**IDX_W entries of 24-bit RGB held as hi/lo nibble arrays, BPLAM-XORed lookup.
// Lookup latency LAT clocks, one result per request; no backpressure, a new lookup every cycle.
module aga_colour_table #(
    parameter int IDX_W = 8,
    parameter int LAT   = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    aga_colour_table_if.slave  bus
);
    localparam int DEPTH = 1 << IDX_W;

    logic [11:0]      r_hi [DEPTH];
    logic [11:0]      r_lo [DEPTH];

    logic [11:0]      r_p_hi  [LAT];
    logic [11:0]      r_p_lo  [LAT];
    logic             r_p_blk [LAT];
    logic             r_p_v   [LAT];

    logic [IDX_W-1:0] w_wa;
    logic [IDX_W-1:0] w_ra;
    logic [11:0]      w_hi;
    logic [11:0]      w_lo;

    // Narrow palettes drop the upper bank bits, so bank select has no effect at IDX_W=5.
    assign w_wa = IDX_W'({bus.cpu_bank, bus.cpu_reg});
    assign w_ra = bus.clut_idx ^ bus.clut_xor;

    // The high-nibble path writes both arrays so a 12-bit colour expands to 8 bits per channel.
    always_ff @(posedge i_clk) begin
        if (bus.cpu_wr) begin
            r_lo[w_wa] <= bus.cpu_rgb;
            if (!bus.cpu_loct) begin
                r_hi[w_wa] <= bus.cpu_rgb;
            end
        end
    end

    // Array read sits in the same edge as any write, which makes collisions read-first.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < LAT; k++) begin
                r_p_hi[k]  <= 12'h000;
                r_p_lo[k]  <= 12'h000;
                r_p_blk[k] <= 1'b0;
                r_p_v[k]   <= 1'b0;
            end
        end else begin
            if (bus.clut_rd) begin
                r_p_hi[0]  <= r_hi[w_ra];
                r_p_lo[0]  <= r_lo[w_ra];
                r_p_blk[0] <= bus.clut_blank;
                r_p_v[0]   <= 1'b1;
            end else begin
                r_p_v[0]   <= 1'b0;
            end
            for (int k = 1; k < LAT; k++) begin
                r_p_hi[k]  <= r_p_hi[k-1];
                r_p_lo[k]  <= r_p_lo[k-1];
                r_p_blk[k] <= r_p_blk[k-1];
                r_p_v[k]   <= r_p_v[k-1];
            end
        end
    end

    assign w_hi = r_p_hi[LAT-1];
    assign w_lo = r_p_lo[LAT-1];

    assign bus.clut_rgb = r_p_blk[LAT-1] ? 24'h000000 :
                          {w_hi[11:8], w_lo[11:8], w_hi[7:4], w_lo[7:4], w_hi[3:0], w_lo[3:0]};
    assign bus.clut_vld = r_p_v[LAT-1];
endmodule
